// File: rtl/str_pkg.sv
// rtl/str_pkg.sv - shared state encoding and default depth for the delay checker
package str_pkg;

    localparam int STR_DEFAULT_DEPTH = 57;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        CHECK = 2'd2
    } str_state_e;

endpackage

// File: rtl/str_delay_checker_if.sv
// rtl/str_delay_checker_if.sv - stream and status bundle between driver and delay checker
interface str_delay_checker_if #(
    parameter int W     = 8,
    parameter int ERR_W = 16
);

    logic             en;
    logic             clr;
    logic [W-1:0]     tx_byte;
    logic [W-1:0]     rx_byte;
    logic             locked;
    logic             mismatch;
    logic [ERR_W-1:0] err_count;
    logic [W-1:0]     last_bad;

    modport master (
        output en, clr, tx_byte, rx_byte,
        input  locked, mismatch, err_count, last_bad
    );

    modport slave (
        input  en, clr, tx_byte, rx_byte,
        output locked, mismatch, err_count, last_bad
    );

endinterface

// File: rtl/str_delay_buf.sv
// rtl/str_delay_buf.sv - DEPTH x W circular store with read-before-write at one address
module str_delay_buf #(
    parameter int DEPTH = 57,
    parameter int W     = 8,
    parameter int IW    = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [IW-1:0] addr,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // Write the incoming byte; contents are deliberately left unreset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Asynchronous read returns the old entry before this edge's overwrite
    assign rdata = mem[addr];

endmodule

// File: rtl/str_delay_checker.sv
// rtl/str_delay_checker.sv - compares rx stream against tx stream delayed by DEPTH cycles
module str_delay_checker
    import str_pkg::*;
#(
    parameter int DEPTH = STR_DEFAULT_DEPTH,
    parameter int W     = 8,
    parameter int ERR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    str_delay_checker_if.slave bus
);

    localparam int AW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    str_state_e       state;
    str_state_e       state_nxt;
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    wptr_nxt;
    logic [AW-1:0]    fill_cnt;
    logic [AW-1:0]    fill_nxt;
    logic             locked_q;
    logic             mismatch_q;
    logic [ERR_W-1:0] err_q;
    logic [W-1:0]     last_bad_q;
    logic [W-1:0]     rd_byte;
    logic             wr_en;
    logic             fail;

    // Only FILL and CHECK cycles with en high push data into the line
    assign wr_en = bus.en && (state != IDLE);
    assign fail  = bus.en && (state == CHECK) && (bus.rx_byte != rd_byte);

    str_delay_buf #(
        .DEPTH (DEPTH),
        .W     (W),
        .IW    (IW)
    ) u_buf (
        .clk   (clk),
        .we    (wr_en),
        .addr  (wptr[IW-1:0]),
        .wdata (bus.tx_byte),
        .rdata (rd_byte)
    );

    // Next state, write pointer and fill count; en low always collapses to IDLE
    always_comb begin
        state_nxt = state;
        wptr_nxt  = wptr;
        fill_nxt  = fill_cnt;
        if (!bus.en) begin
            state_nxt = IDLE;
            wptr_nxt  = '0;
            fill_nxt  = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = FILL;
                    wptr_nxt  = '0;
                    fill_nxt  = '0;
                end
                FILL: begin
                    wptr_nxt = (wptr == LAST) ? '0 : wptr + 1'b1;
                    fill_nxt = fill_cnt + 1'b1;
                    if (fill_cnt == LAST) begin
                        state_nxt = CHECK;
                    end
                end
                CHECK: begin
                    wptr_nxt = (wptr == LAST) ? '0 : wptr + 1'b1;
                end
                default: begin
                    state_nxt = IDLE;
                    wptr_nxt  = '0;
                    fill_nxt  = '0;
                end
            endcase
        end
    end

    // State, pointers and lock flag; locked follows the state it decodes on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wptr     <= '0;
            fill_cnt <= '0;
            locked_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            wptr     <= wptr_nxt;
            fill_cnt <= fill_nxt;
            locked_q <= (state_nxt == CHECK);
        end
    end

    // Error reporting; clr wins over a coincident failure but the pulse still fires
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch_q <= 1'b0;
            err_q      <= '0;
            last_bad_q <= '0;
        end else begin
            mismatch_q <= fail;
            if (bus.clr) begin
                err_q      <= '0;
                last_bad_q <= '0;
            end else if (fail) begin
                last_bad_q <= bus.rx_byte;
                if (err_q != '1) begin
                    err_q <= err_q + 1'b1;
                end
            end
        end
    end

    assign bus.locked    = locked_q;
    assign bus.mismatch  = mismatch_q;
    assign bus.err_count = err_q;
    assign bus.last_bad  = last_bad_q;

endmodule

// File: tb/tb_str_delay_checker.sv
// tb/tb_str_delay_checker.sv - scoreboard bench for str_delay_checker at ERR_W 16 and 4
module tb_str_delay_checker;
    import str_pkg::*;

    localparam int DEPTH = STR_DEFAULT_DEPTH;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] tx = 8'h00;
    logic [7:0] rx = 8'h00;

    always #5 clk = ~clk;

    str_delay_checker_if #(.W(8), .ERR_W(16)) bus_a ();
    str_delay_checker_if #(.W(8), .ERR_W(4))  bus_b ();

    assign bus_a.en = en;  assign bus_a.clr = clr;  assign bus_a.tx_byte = tx;  assign bus_a.rx_byte = rx;
    assign bus_b.en = en;  assign bus_b.clr = clr;  assign bus_b.tx_byte = tx;  assign bus_b.rx_byte = rx;

    str_delay_checker #(.DEPTH(DEPTH), .W(8), .ERR_W(16)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    str_delay_checker #(.DEPTH(DEPTH), .W(8), .ERR_W(4)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    typedef struct {
        logic        mis;
        logic        lock;
        logic [15:0] ea;
        logic [3:0]  eb;
        logic [7:0]  lb;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;

    int         m_phase = 0;
    int         m_fill = 0;
    logic [7:0] m_hist[$];
    int         m_ea = 0;
    int         m_eb = 0;
    logic [7:0] m_lb = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_locked_a"}, 32'(bus_a.locked), 32'd0);
        chk({tag, "_mis_a"},    32'(bus_a.mismatch), 32'd0);
        chk({tag, "_err_a"},    32'(bus_a.err_count), 32'd0);
        chk({tag, "_lb_a"},     32'(bus_a.last_bad), 32'd0);
        chk({tag, "_locked_b"}, 32'(bus_b.locked), 32'd0);
        chk({tag, "_err_b"},    32'(bus_b.err_count), 32'd0);
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_fill  = 0;
        m_hist.delete();
        m_ea    = 0;
        m_eb    = 0;
        m_lb    = 8'h00;
        sb.delete();
    endtask

    // One clock: predict, drive, advance, then compare against the scoreboard head
    task automatic step(input logic e, input logic c, input logic [7:0] t, input logic [7:0] r);
        exp_t x;
        exp_t got;
        logic fail;
        fail = 1'b0;
        if (!e) begin
            m_phase = 0;
        end else if (m_phase == 0) begin
            m_phase = 1;
            m_fill  = 0;
            m_hist.delete();
        end else begin
            if (m_phase == 2) fail = (r !== m_hist[0]);
            m_hist.push_back(t);
            if (m_hist.size() > DEPTH) void'(m_hist.pop_front());
            if (m_phase == 1) begin
                m_fill++;
                if (m_fill == DEPTH) m_phase = 2;
            end
        end
        if (c) begin
            m_ea = 0;
            m_eb = 0;
            m_lb = 8'h00;
        end else if (fail) begin
            m_lb = r;
            if (m_ea < 65535) m_ea++;
            if (m_eb < 15) m_eb++;
        end
        x.mis  = fail;
        x.lock = (m_phase == 2);
        x.ea   = 16'(m_ea);
        x.eb   = 4'(m_eb);
        x.lb   = m_lb;
        sb.push_back(x);

        en  = e;
        clr = c;
        tx  = t;
        rx  = r;
        @(posedge clk);
        #1;
        cyc++;

        got = sb.pop_front();
        chk("mismatch_a", 32'(bus_a.mismatch),  32'(got.mis));
        chk("mismatch_b", 32'(bus_b.mismatch),  32'(got.mis));
        chk("locked_a",   32'(bus_a.locked),    32'(got.lock));
        chk("err_count_a",32'(bus_a.err_count), 32'(got.ea));
        chk("err_count_b",32'(bus_b.err_count), 32'(got.eb));
        chk("last_bad_a", 32'(bus_a.last_bad),  32'(got.lb));
    endtask

    // tx = cycle index, rx = tx from DEPTH cycles ago, optionally corrupted or forced to FF
    task automatic stream(input int n, input logic rx_ff, input int bad_at, input logic clr_at_bad);
        logic [7:0] t;
        logic [7:0] r;
        logic       c;
        for (int i = 0; i < n; i++) begin
            t = 8'(cyc);
            r = rx_ff ? 8'hFF : 8'(cyc - DEPTH);
            c = 1'b0;
            if (i == bad_at) begin
                r = r ^ 8'h01;
                c = clr_at_bad;
            end
            step(1'b1, c, t, r);
        end
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0, 8'(cyc), 8'(cyc - DEPTH));
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        // Lock after one IDLE cycle plus DEPTH fill cycles, then run past a pointer wrap
        stream(1 + DEPTH + 80, 1'b0, -1, 1'b0);

        // Single corrupted byte
        stream(10, 1'b0, 3, 1'b0);

        // Constant FF against counting tx: narrow counter saturates
        stream(22, 1'b1, -1, 1'b0);

        // clr coincident with a failed compare
        stream(5, 1'b0, 2, 1'b1);

        // One more failure so the abort test has a nonzero count to hold
        stream(4, 1'b0, 1, 1'b0);

        // Abort for 3 cycles, then refill and relock with no stale compares
        idle_steps(3);
        stream(1 + DEPTH + 10, 1'b0, -1, 1'b0);

        // Fresh run into mid-FILL, then asynchronous reset between edges
        idle_steps(1);
        stream(20, 1'b0, -1, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        model_reset();
        #3;
        rst_n = 1'b1;

        // Refill from wptr 0 after reset; a stale pointer would produce compare failures
        stream(1 + DEPTH + 10, 1'b0, -1, 1'b0);
        stream(6, 1'b0, 4, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
